cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Sits directly downstream of the pipeline's I-cache and D-cache miss/writeback ports and feeds the single cacheline-wide physical memory port (cacheline adaptor).
- Serialises one 256-bit line transaction at a time.
- Gives the D-side priority, with a starvation guard so fetch is never locked out.
- Latches the request, holds memory signals stable until mem_resp, then returns a one-cycle response to the winning client.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits.
- ADDR_WIDTH, 32, line address width; low 5 bits are passed through unchanged.
- STARVE_LIMIT, 4, consecutive D grants allowed while I waits before I is forced; 0 means strict D priority.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, active low.
- i_pmem_read  in  1  I-cache line read request; held until i_pmem_resp.
- i_pmem_addr  in  ADDR_WIDTH  I-cache line address.
- i_pmem_rdata  out  LINE_WIDTH  line returned to I-cache.
- i_pmem_resp  out  1  one-cycle completion pulse to I-cache.
- d_pmem_read  in  1  D-cache line read request.
- d_pmem_write  in  1  D-cache writeback request.
- d_pmem_addr  in  ADDR_WIDTH  D-cache line address.
- d_pmem_wdata  in  LINE_WIDTH  writeback line.
- d_pmem_rdata  out  LINE_WIDTH  line returned to D-cache.
- d_pmem_resp  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  LINE_WIDTH  memory write line.
- mem_rdata  in  LINE_WIDTH  memory read line.
- mem_resp  in  1  memory completion, one cycle.

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low. The clock port is clk and the reset port is rst.
- Reset values:
  - State IDLE, starve_cnt 0.
  - All outputs 0: mem_read, mem_write, mem_addr, mem_wdata, both resp, both rdata.
  - Assertion of rst clears everything immediately, including mid-transaction. No response is issued for an aborted transaction. Clients re-request after reset.
- States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D.
- IDLE:
  - Grant selection:
    - Grant D if any D request is pending and the starve guard is not tripped.
    - Otherwise grant I if i_pmem_read is asserted.
    - Otherwise remain in IDLE.
  - The starve guard is tripped when STARVE_LIMIT != 0, starve_cnt == STARVE_LIMIT, and i_pmem_read is asserted.
  - On grant, latch addr, wdata and op (read/write) into holding registers. Next state is SERVE_x.
- SERVE_x:
  - mem_read/mem_write/mem_addr/mem_wdata are driven only from the holding registers, stable for the whole state.
  - Client inputs changing during service have no effect.
  - On mem_resp: load mem_rdata into the winner's rdata register (reads only; on writes rdata holds its previous value). Next state is RESP_x.
  - mem_read/mem_write deassert in the cycle after mem_resp.
- RESP_x: x_pmem_resp=1 for exactly one cycle; rdata is valid that cycle and held afterwards. Next state is always IDLE.
  - A client still asserting its request during RESP is not re-granted until IDLE evaluates the next cycle. Clients must drop the request the cycle after resp.
- Latency: request first visible in IDLE at cycle 0; memory strobe at cycle 1; mem_resp at cycle k; client resp at k+1. Minimum turnaround between back-to-back grants is 1 IDLE cycle.
- Starve counter:
  - Increment (saturating at STARVE_LIMIT) on each D grant made while i_pmem_read is asserted.
  - Clear on every I grant.
  - Unchanged otherwise.
- d_pmem_read and d_pmem_write both asserted: treated as write. Simulation-only assertion fires.
- A request dropped during SERVE still completes on memory and still pulses resp.
- mem_resp outside SERVE is ignored.

Decomposition:
- Shared package cache_types:
  - typedef pmem_line_t (LINE_WIDTH logic vector).
  - enum arb_state_t {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D}.
  - localparam default STARVE_LIMIT.
- No new sub-module. The holding and rdata registers reuse the existing width-parameterised register module. FSM and counter stay inline.

Test Plan:
- I only: i_pmem_read=1, addr 0x0000_0060; mem_resp after 3 cycles with 0xAA..AA → mem_read high cycles 1–3; i_pmem_resp pulses cycle 4 with i_pmem_rdata=0xAA..AA; mem_addr=0x60 throughout.
- Simultaneous I read and D write, addr 0x100, wdata 0x55..55 → D served first (mem_write, mem_wdata=0x55..55); d_pmem_resp pulses once; I granted after one IDLE cycle.
- Starvation: i_pmem_read held, D issues 6 back-to-back reads with STARVE_LIMIT=4 → grant order D,D,D,D,I,D,D; starve_cnt returns to 0 after the I grant.
- Input change mid-service: d_pmem_addr changes 0x200→0x300 during SERVE_D → mem_addr stays 0x200 until mem_resp.
- Reset mid-transaction: rst low during SERVE_I → mem_read=0 in the same cycle (async); no i_pmem_resp; state IDLE after release; a fresh request is served normally.
- Spurious mem_resp in IDLE with no requests → no resp pulse; state stays IDLE; rdata unchanged.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared types and defaults for the I/D cache arbiter
package cache_types;

  localparam int PMEM_LINE_WIDTH      = 256;
  localparam int DEFAULT_STARVE_LIMIT = 4;

  typedef logic [PMEM_LINE_WIDTH-1:0] pmem_line_t;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP_I,
    RESP_D
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter_reg.sv
// rtl/cache_arbiter_reg.sv - width-parameterised load-enable register, async active-low clear
module cache_arbiter_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - serialises I-cache and D-cache line transactions onto one memory port
module cache_arbiter
  import cache_types::*;
#(
  parameter int LINE_WIDTH   = PMEM_LINE_WIDTH,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_addr,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_addr,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  // Counter is always at least one bit so STARVE_LIMIT = 0 still elaborates.
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t state, state_next;
  logic [CNT_W-1:0] starve_cnt, starve_next;

  logic d_req, starve_trip, grant_d, grant_i, grant;
  logic hold_write;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [LINE_WIDTH-1:0] hold_wdata;
  logic load_i_rdata, load_d_rdata;

  assign d_req       = d_pmem_read | d_pmem_write;
  assign starve_trip = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT) && i_pmem_read;
  assign grant_d     = (state == IDLE) && d_req && !starve_trip;
  assign grant_i     = (state == IDLE) && !grant_d && i_pmem_read;
  assign grant       = grant_d | grant_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_next = SERVE_D;
          if (i_pmem_read && (starve_cnt != LIMIT)) begin
            starve_next = starve_cnt + 1'b1;
          end
        end else if (grant_i) begin
          state_next  = SERVE_I;
          starve_next = '0;
        end
      end
      SERVE_I: if (mem_resp) state_next = RESP_I;
      SERVE_D: if (mem_resp) state_next = RESP_D;
      RESP_I:  state_next = IDLE;
      RESP_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Simultaneous read and write from the D-cache is resolved as a write.
  cache_arbiter_reg #(.WIDTH(1)) u_hold_write (
    .clk  (clk),
    .rst  (rst),
    .load (grant),
    .din  (grant_d & d_pmem_write),
    .dout (hold_write)
  );

  cache_arbiter_reg #(.WIDTH(ADDR_WIDTH)) u_hold_addr (
    .clk  (clk),
    .rst  (rst),
    .load (grant),
    .din  (grant_d ? d_pmem_addr : i_pmem_addr),
    .dout (hold_addr)
  );

  cache_arbiter_reg #(.WIDTH(LINE_WIDTH)) u_hold_wdata (
    .clk  (clk),
    .rst  (rst),
    .load (grant_d),
    .din  (d_pmem_wdata),
    .dout (hold_wdata)
  );

  assign load_i_rdata = (state == SERVE_I) && mem_resp;
  assign load_d_rdata = (state == SERVE_D) && mem_resp && !hold_write;

  cache_arbiter_reg #(.WIDTH(LINE_WIDTH)) u_i_rdata (
    .clk  (clk),
    .rst  (rst),
    .load (load_i_rdata),
    .din  (mem_rdata),
    .dout (i_pmem_rdata)
  );

  cache_arbiter_reg #(.WIDTH(LINE_WIDTH)) u_d_rdata (
    .clk  (clk),
    .rst  (rst),
    .load (load_d_rdata),
    .din  (mem_rdata),
    .dout (d_pmem_rdata)
  );

  // Memory strobes come from state so an async reset drops them immediately.
  assign mem_read    = ((state == SERVE_I) || (state == SERVE_D)) && !hold_write;
  assign mem_write   = (state == SERVE_D) && hold_write;
  assign mem_addr    = hold_addr;
  assign mem_wdata   = hold_wdata;
  assign i_pmem_resp = (state == RESP_I);
  assign d_pmem_resp = (state == RESP_D);

  assert property (@(posedge clk) disable iff (!rst) !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - scoreboard bench for cache_arbiter with a latency-3 memory responder
module tb_cache_arbiter;
  import cache_types::*;

  localparam int MEM_LAT = 3;

  typedef struct {
    bit         is_d;
    pmem_line_t rdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        i_pmem_read;
  logic [31:0] i_pmem_addr;
  pmem_line_t  i_pmem_rdata;
  logic        i_pmem_resp;
  logic        d_pmem_read;
  logic        d_pmem_write;
  logic [31:0] d_pmem_addr;
  pmem_line_t  d_pmem_wdata;
  pmem_line_t  d_pmem_rdata;
  logic        d_pmem_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  pmem_line_t  mem_wdata;
  pmem_line_t  mem_rdata;
  logic        mem_resp;

  int applied = 0;
  int miscompares = 0;
  int strobe_cnt = 0;
  int spur_req = 0;
  int spur_done = 0;
  exp_t exp_q[$];
  logic [31:0] grant_log[$];
  pmem_line_t last_i, last_d;

  cache_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_pmem_read  (i_pmem_read),
    .i_pmem_addr  (i_pmem_addr),
    .i_pmem_rdata (i_pmem_rdata),
    .i_pmem_resp  (i_pmem_resp),
    .d_pmem_read  (d_pmem_read),
    .d_pmem_write (d_pmem_write),
    .d_pmem_addr  (d_pmem_addr),
    .d_pmem_wdata (d_pmem_wdata),
    .d_pmem_rdata (d_pmem_rdata),
    .d_pmem_resp  (d_pmem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pmem_line_t line_for(input logic [31:0] addr);
    if (addr == 32'h60) return {32{8'hAA}};
    return {8{addr}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
    applied++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push_exp(input bit is_d, input pmem_line_t rdata);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(input bit is_d, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? d_pmem_resp : i_pmem_resp) && n < 50);
    chk(name, is_d ? d_pmem_resp : i_pmem_resp, 1'b1);
    @(posedge clk);
    #1;
    if (is_d) begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end else begin
      i_pmem_read = 1'b0;
    end
  endtask

  // Memory model: answers each strobe on its MEM_LAT-th cycle, or injects a stray mem_resp on request.
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (spur_req != spur_done) begin
        spur_done = spur_req;
        mem_resp  = 1'b1;
        mem_rdata = {32{8'hEE}};
      end else if (mem_resp) begin
        mem_resp = 1'b0;
      end else if ((mem_read || mem_write) && rst) begin
        strobe_cnt++;
        if (strobe_cnt == MEM_LAT) begin
          mem_resp   = 1'b1;
          mem_rdata  = line_for(mem_addr);
          grant_log.push_back(mem_addr);
          strobe_cnt = 0;
        end
      end else begin
        strobe_cnt = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_pmem_resp || d_pmem_resp) begin
        if (i_pmem_resp && d_pmem_resp) chk("resp_exclusive", 2'b11, 2'b01);
        if (exp_q.size() == 0) begin
          applied++;
          miscompares++;
          $display("FAIL unexpected_resp: got i=%0b d=%0b expected no response", i_pmem_resp, d_pmem_resp);
        end else begin
          e = exp_q.pop_front();
          chk("resp_side", d_pmem_resp, e.is_d);
          chk("resp_rdata", e.is_d ? d_pmem_rdata : i_pmem_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_addrs[7];
    int d_done, n;
    bit i_done, d_seen, i_seen;

    rst = 1'b0;
    i_pmem_read = 1'b0; i_pmem_addr = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_addr = '0; d_pmem_wdata = '0;
    last_i = '0; last_d = '0;

    repeat (2) @(negedge clk);
    chk("reset_mem_read", mem_read, 1'b0);
    chk("reset_mem_write", mem_write, 1'b0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, '0);
    chk("reset_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
    chk("reset_i_rdata", i_pmem_rdata, '0);
    chk("reset_d_rdata", d_pmem_rdata, '0);
    chk("reset_state", dut.state, IDLE);
    @(posedge clk); #1 rst = 1'b1;

    // I-side read alone
    @(posedge clk); #1;
    i_pmem_read = 1'b1; i_pmem_addr = 32'h60;
    push_exp(1'b0, {32{8'hAA}}); last_i = {32{8'hAA}};
    @(negedge clk);
    chk("t1_c0_mem_read", mem_read, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("t1_mem_read_held", mem_read, 1'b1);
      chk("t1_mem_addr", mem_addr, 32'h60);
    end
    @(negedge clk);
    chk("t1_c4_i_resp", i_pmem_resp, 1'b1);
    chk("t1_c4_mem_read_low", mem_read, 1'b0);
    @(posedge clk); #1 i_pmem_read = 1'b0;

    // Simultaneous I read and D write: D wins
    @(posedge clk); #1;
    i_pmem_read = 1'b1; i_pmem_addr = 32'h60;
    d_pmem_write = 1'b1; d_pmem_addr = 32'h100; d_pmem_wdata = {32{8'h55}};
    push_exp(1'b1, last_d);
    push_exp(1'b0, {32{8'hAA}});
    @(negedge clk);
    @(negedge clk);
    chk("t2_mem_write", mem_write, 1'b1);
    chk("t2_mem_read", mem_read, 1'b0);
    chk("t2_mem_addr", mem_addr, 32'h100);
    chk("t2_mem_wdata", mem_wdata, {32{8'h55}});
    wait_resp(1'b1, "t2_d_resp");
    @(negedge clk);
    chk("t2_idle_gap", {mem_read, mem_write}, 2'b00);
    @(negedge clk);
    chk("t2_i_granted", mem_read, 1'b1);
    chk("t2_i_addr", mem_addr, 32'h60);
    wait_resp(1'b0, "t2_i_resp");

    // Starvation guard: D streams six reads while I waits
    grant_log.delete();
    for (int k = 0; k < 4; k++) exp_addrs[k] = 32'h1000 + 32'(k) * 32'h20;
    exp_addrs[4] = 32'h60;
    exp_addrs[5] = 32'h1080;
    exp_addrs[6] = 32'h10A0;
    for (int k = 0; k < 7; k++) begin
      push_exp(k != 4, line_for(exp_addrs[k]));
    end
    last_d = line_for(32'h10A0);
    @(posedge clk); #1;
    i_pmem_read = 1'b1; i_pmem_addr = 32'h60;
    d_pmem_read = 1'b1; d_pmem_addr = 32'h1000;
    d_done = 0; i_done = 1'b0; n = 0;
    while (!(d_done == 6 && i_done) && n < 200) begin
      @(negedge clk);
      d_seen = d_pmem_resp;
      i_seen = i_pmem_resp;
      @(posedge clk); #1;
      n++;
      if (d_seen) begin
        d_done++;
        if (d_done < 6) d_pmem_addr = 32'h1000 + 32'(d_done) * 32'h20;
        else d_pmem_read = 1'b0;
      end
      if (i_seen) begin
        i_done = 1'b1;
        i_pmem_read = 1'b0;
      end
    end
    chk("t3_completed", {i_done, 8'(d_done)}, {1'b1, 8'd6});
    chk("t3_grant_count", grant_log.size(), 7);
    for (int k = 0; k < 7; k++) begin
      if (k < grant_log.size()) chk("t3_grant_order", grant_log[k], exp_addrs[k]);
    end
    chk("t3_starve_cnt_cleared", dut.starve_cnt, 0);

    // D address changes mid-service
    @(posedge clk); #1;
    d_pmem_read = 1'b1; d_pmem_addr = 32'h200;
    push_exp(1'b1, line_for(32'h200)); last_d = line_for(32'h200);
    @(negedge clk);
    @(negedge clk);
    chk("t4_addr_c1", mem_addr, 32'h200);
    #1 d_pmem_addr = 32'h300;
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      chk("t4_addr_stable", mem_addr, 32'h200);
      chk("t4_mem_read", mem_read, 1'b1);
    end
    wait_resp(1'b1, "t4_d_resp");

    // Reset during SERVE_I aborts without a response
    @(posedge clk); #1;
    i_pmem_read = 1'b1; i_pmem_addr = 32'h60;
    @(negedge clk);
    @(negedge clk);
    chk("t5_serving", mem_read, 1'b1);
    #2 rst = 1'b0; i_pmem_read = 1'b0;
    #1;
    chk("t5_async_mem_read", mem_read, 1'b0);
    chk("t5_async_state", dut.state, IDLE);
    last_i = '0; last_d = '0;
    chk("t5_i_rdata_cleared", i_pmem_rdata, '0);
    chk("t5_d_rdata_cleared", d_pmem_rdata, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t5_state_after", dut.state, IDLE);
    chk("t5_no_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(posedge clk); #1;
    i_pmem_read = 1'b1; i_pmem_addr = 32'h60;
    push_exp(1'b0, {32{8'hAA}}); last_i = {32{8'hAA}};
    wait_resp(1'b0, "t5_fresh_i_resp");

    // Stray mem_resp while idle
    @(posedge clk); #1 spur_req++;
    repeat (3) begin
      @(negedge clk);
      chk("t6_state_idle", dut.state, IDLE);
    end
    chk("t6_i_rdata_held", i_pmem_rdata, last_i);
    chk("t6_d_rdata_held", d_pmem_rdata, last_d);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
